// File: rtl/flash_rom_fetch.sv
// Serves 6809 reads in the 0xF000-0xFFFF ROM window from an external SPI flash using
// one 0x03 READ per byte. A one-entry cache answers repeats, and the pins are yielded to the FT2232.
module flash_rom_fetch #(
    parameter int unsigned CLK_DIV     = 4,
    parameter logic [23:0] BASE_ADDR   = 24'h000000,
    parameter int unsigned CS_HIGH_MIN = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_spi_ce,
    input  logic [15:0] i_ADDRESS_BUS,
    input  logic        i_RW,
    input  logic        i_Q,
    input  logic        i_E,
    input  logic        i_FT_CS,
    input  logic        i_SPI_MISO,
    output logic        o_SPI_CLK,
    output logic        o_SPI_MOSI,
    output logic        o_SPI_CS,
    output logic        o_spi_own,
    output logic [7:0]  o_DATA,
    output logic        o_data_valid,
    output logic        o_MRDY
);

    localparam int DIV_W = $clog2(CLK_DIV) + 1;
    localparam int GAP_W = $clog2(CS_HIGH_MIN + 1) + 1;
    localparam logic [DIV_W-1:0] DIV_TC = DIV_W'(CLK_DIV - 1);
    localparam logic [GAP_W-1:0] GAP_TC = GAP_W'(CS_HIGH_MIN - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_CMD  = 3'd1,
        S_DATA = 3'd2,
        S_DONE = 3'd3,
        S_GAP  = 3'd4
    } state_t;

    state_t state_r;
    state_t next_state_s;

    // synchronizer bit order: {ft_cs, e, q, rw, spi_ce}
    logic [4:0]       sync1_r;
    logic [4:0]       sync2_r;
    logic             q_d_r;
    logic             e_d_r;

    logic             sck_r;
    logic             mosi_r;
    logic             cs_n_r;
    logic             own_r;
    logic [DIV_W-1:0] div_cnt_r;
    logic [5:0]       bit_cnt_r;
    logic [31:0]      shift_r;
    logic [7:0]       rx_r;
    logic [GAP_W-1:0] gap_cnt_r;

    logic [7:0]       data_r;
    logic             valid_r;
    logic             mrdy_r;
    logic [11:0]      tag_r;
    logic             cache_valid_r;
    logic             pend_r;
    logic [11:0]      addr_r;

    logic             ce_s;
    logic             rw_s;
    logic             q_s;
    logic             e_s;
    logic             ft_s;
    logic             q_rise_s;
    logic             e_fall_s;
    logic             win_s;
    logic             capture_s;
    logic             hit_s;
    logic             div_tc_s;
    logic             sck_fall_s;
    logic             cmd_end_s;
    logic             last_bit_s;
    logic             launch_s;
    logic [11:0]      launch_addr_s;
    logic [31:0]      launch_word_s;

    assign ce_s          = sync2_r[0];
    assign rw_s          = sync2_r[1];
    assign q_s           = sync2_r[2];
    assign e_s           = sync2_r[3];
    assign ft_s          = sync2_r[4];
    assign q_rise_s      = q_s & ~q_d_r;
    assign e_fall_s      = ~e_s & e_d_r;
    // the decoder already qualifies the window; the top nibble check guards against a glitchy spi_ce
    assign win_s         = (i_ADDRESS_BUS[15:12] == 4'hF);
    assign capture_s     = q_rise_s & ce_s & rw_s & ft_s & win_s;
    assign hit_s         = cache_valid_r & (tag_r == i_ADDRESS_BUS[11:0]);
    assign div_tc_s      = (div_cnt_r == DIV_TC);
    assign sck_fall_s    = div_tc_s & sck_r;
    assign cmd_end_s     = (bit_cnt_r == 6'd31);
    assign last_bit_s    = (bit_cnt_r == 6'd39);
    assign launch_s      = (state_r == S_IDLE) & ft_s & (pend_r | (capture_s & ~hit_s));
    assign launch_addr_s = pend_r ? addr_r : i_ADDRESS_BUS[11:0];
    assign launch_word_s = {8'h03, BASE_ADDR[23:12], launch_addr_s};

    assign o_SPI_CLK    = sck_r;
    assign o_SPI_MOSI   = mosi_r;
    assign o_SPI_CS     = cs_n_r;
    assign o_spi_own    = own_r;
    assign o_DATA       = data_r;
    assign o_data_valid = valid_r;
    assign o_MRDY       = mrdy_r;

    // Two-flop synchronizers plus previous-value flops for Q/E edge detection
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_r <= 5'b00000;
            sync2_r <= 5'b00000;
            q_d_r   <= 1'b0;
            e_d_r   <= 1'b0;
        end else begin
            sync1_r <= {i_FT_CS, i_E, i_Q, i_RW, i_spi_ce};
            sync2_r <= sync1_r;
            q_d_r   <= sync2_r[2];
            e_d_r   <= sync2_r[3];
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic; the programmer taking the bus forces IDLE from any state
    always_comb begin
        next_state_s = state_r;
        if (!ft_s) begin
            next_state_s = S_IDLE;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (launch_s) begin
                        next_state_s = S_CMD;
                    end else begin
                        next_state_s = S_IDLE;
                    end
                end
                S_CMD: begin
                    if (sck_fall_s && cmd_end_s) begin
                        next_state_s = S_DATA;
                    end else begin
                        next_state_s = S_CMD;
                    end
                end
                S_DATA: begin
                    if (sck_fall_s && last_bit_s) begin
                        next_state_s = S_DONE;
                    end else begin
                        next_state_s = S_DATA;
                    end
                end
                S_DONE: begin
                    next_state_s = S_GAP;
                end
                S_GAP: begin
                    if (gap_cnt_r == GAP_TC) begin
                        next_state_s = S_IDLE;
                    end else begin
                        next_state_s = S_GAP;
                    end
                end
                default: begin
                    next_state_s = S_IDLE;
                end
            endcase
        end
    end

    // SPI engine: mode-0 SCK divider, command shifter, MISO sampler and CS gap timer
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sck_r     <= 1'b0;
            mosi_r    <= 1'b0;
            cs_n_r    <= 1'b1;
            own_r     <= 1'b0;
            div_cnt_r <= {DIV_W{1'b0}};
            bit_cnt_r <= 6'd0;
            shift_r   <= 32'h0000_0000;
            rx_r      <= 8'h00;
            gap_cnt_r <= {GAP_W{1'b0}};
        end else if (!ft_s) begin
            sck_r     <= 1'b0;
            mosi_r    <= 1'b0;
            cs_n_r    <= 1'b1;
            own_r     <= 1'b0;
            div_cnt_r <= {DIV_W{1'b0}};
            bit_cnt_r <= 6'd0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (launch_s) begin
                        shift_r   <= launch_word_s;
                        mosi_r    <= launch_word_s[31];
                        cs_n_r    <= 1'b0;
                        sck_r     <= 1'b0;
                        own_r     <= 1'b1;
                        // all-ones wraps through zero: first low half gets one extra clk of CS setup
                        div_cnt_r <= {DIV_W{1'b1}};
                        bit_cnt_r <= 6'd0;
                    end else begin
                        cs_n_r <= 1'b1;
                        own_r  <= 1'b0;
                    end
                end
                S_CMD, S_DATA: begin
                    if (div_tc_s) begin
                        div_cnt_r <= {DIV_W{1'b0}};
                        sck_r     <= ~sck_r;
                        if (!sck_r) begin
                            if (state_r == S_DATA) begin
                                rx_r <= {rx_r[6:0], i_SPI_MISO};
                            end
                        end else begin
                            shift_r <= {shift_r[30:0], 1'b0};
                            if (state_r == S_DATA && last_bit_s) begin
                                bit_cnt_r <= 6'd0;
                                mosi_r    <= 1'b0;
                                cs_n_r    <= 1'b1;
                            end else begin
                                bit_cnt_r <= bit_cnt_r + 6'd1;
                                mosi_r    <= shift_r[30];
                            end
                        end
                    end else begin
                        div_cnt_r <= div_cnt_r + DIV_W'(1);
                    end
                end
                S_DONE: begin
                    gap_cnt_r <= {GAP_W{1'b0}};
                end
                S_GAP: begin
                    gap_cnt_r <= gap_cnt_r + GAP_W'(1);
                end
                default: begin
                    cs_n_r <= 1'b1;
                end
            endcase
        end
    end

    // CPU side: stall control, returned byte, hit cache and pending capture
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_r        <= 8'hFF;
            valid_r       <= 1'b0;
            mrdy_r        <= 1'b1;
            tag_r         <= 12'h000;
            cache_valid_r <= 1'b0;
            pend_r        <= 1'b0;
            addr_r        <= 12'h000;
        end else if (!ft_s) begin
            cache_valid_r <= 1'b0;
            pend_r        <= 1'b0;
            mrdy_r        <= 1'b1;
            if (!mrdy_r) begin
                data_r  <= 8'hFF;
                valid_r <= 1'b1;
            end else if (e_fall_s) begin
                valid_r <= 1'b0;
            end
        end else begin
            if (e_fall_s) begin
                valid_r <= 1'b0;
            end
            // data_r doubles as the cached byte: only a completed fetch writes it while the cache is valid
            case (state_r)
                S_IDLE: begin
                    if (launch_s) begin
                        addr_r <= launch_addr_s;
                        mrdy_r <= 1'b0;
                        pend_r <= 1'b0;
                    end else if (capture_s && hit_s) begin
                        valid_r <= 1'b1;
                    end
                end
                S_DATA: begin
                    if (sck_fall_s && last_bit_s) begin
                        data_r        <= rx_r;
                        valid_r       <= 1'b1;
                        mrdy_r        <= 1'b1;
                        tag_r         <= addr_r;
                        cache_valid_r <= 1'b1;
                    end
                end
                S_DONE, S_GAP: begin
                    if (capture_s) begin
                        if (hit_s) begin
                            valid_r <= 1'b1;
                        end else begin
                            pend_r <= 1'b1;
                            addr_r <= i_ADDRESS_BUS[11:0];
                            mrdy_r <= 1'b0;
                        end
                    end
                end
                default: begin
                    pend_r <= pend_r;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_flash_rom_fetch.sv
// Bench for flash_rom_fetch: a 6809 bus-cycle driver, a behavioural SPI flash and a
// scoreboard of expected READ commands and returned bytes.
module tb_flash_rom_fetch;

    localparam int          CLK_DIV = 2;
    localparam logic [23:0] BASE    = 24'h010000;
    localparam int          CS_MIN  = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        spi_ce;
    logic [15:0] addr_bus;
    logic        rw;
    logic        q;
    logic        e;
    logic        ft_cs;
    logic        spi_miso;
    logic        spi_clk;
    logic        spi_mosi;
    logic        spi_cs;
    logic        spi_own;
    logic [7:0]  data;
    logic        data_valid;
    logic        mrdy;

    always #5 clk = ~clk;

    flash_rom_fetch #(
        .CLK_DIV    (CLK_DIV),
        .BASE_ADDR  (BASE),
        .CS_HIGH_MIN(CS_MIN)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_spi_ce     (spi_ce),
        .i_ADDRESS_BUS(addr_bus),
        .i_RW         (rw),
        .i_Q          (q),
        .i_E          (e),
        .i_FT_CS      (ft_cs),
        .i_SPI_MISO   (spi_miso),
        .o_SPI_CLK    (spi_clk),
        .o_SPI_MOSI   (spi_mosi),
        .o_SPI_CS     (spi_cs),
        .o_spi_own    (spi_own),
        .o_DATA       (data),
        .o_data_valid (data_valid),
        .o_MRDY       (mrdy)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // flash content model
    function automatic logic [7:0] flash_data(input logic [23:0] a);
        return (a == 24'h010123) ? 8'hA5 : (a[7:0] ^ 8'h5C);
    endfunction

    // ---------------- SPI flash model ----------------
    int          bitn      = 0;
    logic [31:0] cmd_sh    = 32'h0;
    int          sck_rises = 0;
    int          cs_falls  = 0;
    logic        in_txn    = 1'b0;
    logic [31:0] obs_cmd_q[$];
    int          obs_bits_q[$];

    always @(negedge spi_cs) begin
        bitn   = 0;
        cmd_sh = 32'h0;
        in_txn = 1'b1;
        cs_falls++;
    end

    always @(posedge spi_cs) begin
        if (in_txn) begin
            obs_cmd_q.push_back(cmd_sh);
            obs_bits_q.push_back(bitn);
            in_txn = 1'b0;
        end
    end

    always @(posedge spi_clk) begin
        sck_rises++;
        if (spi_cs === 1'b0) begin
            if (bitn < 32) cmd_sh = {cmd_sh[30:0], spi_mosi};
            bitn++;
        end
    end

    always @(negedge spi_clk) begin
        logic [7:0] fb;
        if (spi_cs === 1'b0 && bitn >= 32 && bitn < 40) begin
            fb       = flash_data(cmd_sh[23:0]);
            spi_miso = fb[39 - bitn];
        end
    end

    // ---------------- MRDY-low and CS-high duration monitor ----------------
    int mrdy_lo_cnt = 0;
    int last_lo     = 0;
    int mrdy_lows   = 0;
    int cs_hi_cnt   = 0;
    int last_gap    = 0;

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (mrdy === 1'b0) begin
                mrdy_lo_cnt++;
            end else if (mrdy_lo_cnt > 0) begin
                last_lo     = mrdy_lo_cnt;
                mrdy_lo_cnt = 0;
                mrdy_lows++;
            end
            if (spi_cs === 1'b1) begin
                cs_hi_cnt++;
            end else if (cs_hi_cnt > 0) begin
                last_gap  = cs_hi_cnt;
                cs_hi_cnt = 0;
            end
        end
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        logic [31:0] cmd;
        logic [7:0]  data;
    } exp_t;
    exp_t exp_q[$];

    task automatic expect_miss(input logic [15:0] a);
        exp_t x;
        x.cmd  = {8'h03, BASE[23:12], a[11:0]};
        x.data = flash_data({BASE[23:12], a[11:0]});
        exp_q.push_back(x);
    endtask

    task automatic score(input string tag);
        exp_t        x;
        logic [31:0] c;
        int          b;
        for (int i = 0; i < 100 && obs_cmd_q.size() == 0; i++) @(negedge clk);
        check_eq({tag, "_obs"}, 32'(obs_cmd_q.size() > 0), 32'd1);
        if (obs_cmd_q.size() > 0 && exp_q.size() > 0) begin
            x = exp_q.pop_front();
            c = obs_cmd_q.pop_front();
            b = obs_bits_q.pop_front();
            check_eq({tag, "_cmd"}, c, x.cmd);
            check_eq({tag, "_bits"}, 32'(b), 32'd40);
            check_eq({tag, "_data"}, 32'(data), 32'(x.data));
            check_eq({tag, "_valid"}, 32'(data_valid), 32'd1);
        end
    endtask

    // ---------------- 6809 bus cycle driver ----------------
    task automatic cpu_start(input logic [15:0] a, input logic r, input logic c);
        @(negedge clk);
        addr_bus = a;
        rw       = r;
        spi_ce   = c;
        repeat (4) @(negedge clk);
        q = 1'b1;
    endtask

    task automatic cpu_mid();
        repeat (4) @(negedge clk);
        e = 1'b1;
        repeat (4) @(negedge clk);
        q = 1'b0;
        for (int i = 0; i < 2000 && mrdy !== 1'b1; i++) @(negedge clk);
        check_eq("mrdy_release", 32'(mrdy), 32'd1);
    endtask

    task automatic cpu_fin();
        repeat (4) @(negedge clk);
        e = 1'b0;
        repeat (6) @(negedge clk);
        spi_ce = 1'b0;
        rw     = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "time limit");
    end

    initial begin
        int          r0;
        int          c0;
        int          m0;
        int          ab;
        rst_n    = 1'b0;
        spi_ce   = 1'b0;
        addr_bus = 16'h0000;
        rw       = 1'b1;
        q        = 1'b0;
        e        = 1'b0;
        ft_cs    = 1'b1;
        spi_miso = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_cs",    32'(spi_cs),     32'd1);
        check_eq("rst_sck",   32'(spi_clk),    32'd0);
        check_eq("rst_mosi",  32'(spi_mosi),   32'd0);
        check_eq("rst_mrdy",  32'(mrdy),       32'd1);
        check_eq("rst_data",  32'(data),       32'hFF);
        check_eq("rst_own",   32'(spi_own),    32'd0);
        check_eq("rst_valid", 32'(data_valid), 32'd0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // first read after reset must miss
        cpu_start(16'hF123, 1'b1, 1'b1);
        expect_miss(16'hF123);
        cpu_mid();
        score("miss1");
        cpu_fin();
        check_eq("miss1_valid_clr", 32'(data_valid), 32'd0);
        check_eq("miss1_mrdy_lo", 32'(last_lo), 32'(40 * 2 * CLK_DIV + 1));

        // repeat read hits the cache
        r0 = sck_rises; c0 = cs_falls; m0 = mrdy_lows;
        cpu_start(16'hF123, 1'b1, 1'b1);
        @(negedge clk);
        @(negedge clk);
        check_eq("hit_valid_2clk", 32'(data_valid), 32'd0);
        @(negedge clk);
        check_eq("hit_valid_3clk", 32'(data_valid), 32'd1);
        check_eq("hit_data", 32'(data), 32'hA5);
        cpu_mid();
        cpu_fin();
        check_eq("hit_sck", 32'(sck_rises), 32'(r0));
        check_eq("hit_cs", 32'(cs_falls), 32'(c0));
        check_eq("hit_mrdy", 32'(mrdy_lows), 32'(m0));

        // write cycle in the window and a read outside it are ignored
        r0 = sck_rises; c0 = cs_falls; m0 = mrdy_lows;
        cpu_start(16'hF010, 1'b0, 1'b1);
        cpu_mid();
        cpu_fin();
        cpu_start(16'h0100, 1'b1, 1'b0);
        cpu_mid();
        cpu_fin();
        check_eq("filt_sck", 32'(sck_rises), 32'(r0));
        check_eq("filt_cs", 32'(cs_falls), 32'(c0));
        check_eq("filt_mrdy", 32'(mrdy_lows), 32'(m0));

        // programmer grabs the flash mid-command
        cpu_start(16'hF200, 1'b1, 1'b1);
        for (int i = 0; i < 500 && !(spi_cs === 1'b0 && bitn >= 20); i++) @(negedge clk);
        check_eq("abort_reached_bit20", 32'(bitn >= 20), 32'd1);
        ft_cs = 1'b0;
        repeat (4) @(negedge clk);
        check_eq("abort_cs",    32'(spi_cs),     32'd1);
        check_eq("abort_sck",   32'(spi_clk),    32'd0);
        check_eq("abort_own",   32'(spi_own),    32'd0);
        check_eq("abort_mrdy",  32'(mrdy),       32'd1);
        check_eq("abort_data",  32'(data),       32'hFF);
        check_eq("abort_valid", 32'(data_valid), 32'd1);
        check_eq("abort_obs", 32'(obs_cmd_q.size() > 0), 32'd1);
        if (obs_cmd_q.size() > 0) begin
            void'(obs_cmd_q.pop_front());
            ab = obs_bits_q.pop_front();
            check_eq("abort_bits_lt40", 32'(ab < 40), 32'd1);
        end
        repeat (4) @(negedge clk);
        ft_cs = 1'b1;
        cpu_mid();
        cpu_fin();

        // cache was invalidated by the programmer
        cpu_start(16'hF123, 1'b1, 1'b1);
        expect_miss(16'hF123);
        cpu_mid();
        score("reread");
        cpu_fin();

        // back-to-back: second Q rise lands in the CS-high gap
        cpu_start(16'hF000, 1'b1, 1'b1);
        expect_miss(16'hF000);
        cpu_mid();
        score("b2b1");
        e        = 1'b0;
        addr_bus = 16'hF001;
        @(negedge clk);
        q = 1'b1;
        expect_miss(16'hF001);
        cpu_mid();
        score("b2b2");
        check_eq("b2b_gap", 32'(last_gap >= CS_MIN), 32'd1);
        cpu_fin();

        repeat (5) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
